// File: rtl/cacode_pkg.sv
// Shared constants, config record and LFSR helpers for the multi-channel GPS L1 C/A code generator.
package cacode_pkg;

   localparam logic [9:0]  G1_TAPS       = 10'b10_0000_0100;  // stages 3,10
   localparam logic [9:0]  G2_TAPS       = 10'b11_1010_0110;  // stages 2,3,6,8,9,10
   localparam logic [9:0]  SEED_ALL_ONES = 10'h3FF;
   localparam int unsigned CODE_LEN      = 1023;
   localparam logic [9:0]  IDX_LAST      = 10'(CODE_LEN - 1);
   localparam int unsigned OMEGA_MAX_W   = 32;

   typedef enum logic {
      MODE_FULL  = 1'b0,
      MODE_OMEGA = 1'b1
   } cfg_mode_e;

   typedef struct packed {
      cfg_mode_e              mode;
      logic                   en;
      logic [9:0]             g1;
      logic [9:0]             g2;
      logic [9:0]             idx;
      logic [3:0]             t0;
      logic [3:0]             t1;
      logic [OMEGA_MAX_W-1:0] omega;
   } cfg_t;

   function automatic logic [9:0] lfsr_step(input logic [9:0] state, input logic [9:0] taps);
      return {state[8:0], ^(state & taps)};
   endfunction

   function automatic logic g2_tap(input logic [9:0] g2, input logic [3:0] t);
      logic bit_v;
      if ((t >= 4'd1) && (t <= 4'd10)) begin
         bit_v = g2[t - 4'd1];
      end else begin
         bit_v = 1'b0;
      end
      return bit_v;
   endfunction

endpackage

// File: rtl/cacode_chan.sv
// One C/A code channel: NCO chip clock, G1/G2 LFSRs, chip index and PRN tap selection.
module cacode_chan
   import cacode_pkg::*;
#(
   parameter int NCO_W = 16
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       load,
   input  logic       omega_upd,
   input  cfg_t       cfg,
   output logic       chip,
   output logic       chip_stb,
   output logic       epoch,
   output logic [9:0] chip_idx
);

   logic [9:0]       g1_r;
   logic [9:0]       g2_r;
   logic [9:0]       idx_r;
   logic [NCO_W-1:0] acc_r;
   logic [NCO_W-1:0] omega_r;
   logic             en_r;
   logic [3:0]       t0_r;
   logic [3:0]       t1_r;
   logic             stb_r;
   logic             epoch_r;
   logic [NCO_W:0]   sum_s;
   logic             carry_s;
   logic [9:0]       idx_load_s;
   logic [9:0]       idx_next_s;
   logic             unused_cfg_s;

   // NCO sum, carry qualification, clamped load index and wrapped next index
   always_comb begin
      sum_s   = {1'b0, acc_r} + {1'b0, omega_r};
      carry_s = en_r & sum_s[NCO_W];
      if (cfg.idx > IDX_LAST) begin
         idx_load_s = IDX_LAST;
      end else begin
         idx_load_s = cfg.idx;
      end
      if (idx_r == IDX_LAST) begin
         idx_next_s = 10'd0;
      end else begin
         idx_next_s = idx_r + 10'd1;
      end
   end

   // Channel state: reset, full load (wins over a coincident carry), or NCO/LFSR advance
   always_ff @(posedge clk) begin
      if (!rst) begin
         g1_r    <= SEED_ALL_ONES;
         g2_r    <= SEED_ALL_ONES;
         idx_r   <= 10'd0;
         acc_r   <= {NCO_W{1'b0}};
         omega_r <= {NCO_W{1'b0}};
         en_r    <= 1'b0;
         t0_r    <= 4'd2;
         t1_r    <= 4'd6;
         stb_r   <= 1'b0;
         epoch_r <= 1'b0;
      end else if (load) begin
         g1_r    <= cfg.g1;
         g2_r    <= cfg.g2;
         idx_r   <= idx_load_s;
         acc_r   <= {NCO_W{1'b0}};
         omega_r <= cfg.omega[NCO_W-1:0];
         en_r    <= cfg.en;
         t0_r    <= cfg.t0;
         t1_r    <= cfg.t1;
         stb_r   <= 1'b0;
         epoch_r <= 1'b0;
      end else begin
         stb_r   <= carry_s;
         epoch_r <= carry_s & (idx_r == IDX_LAST);
         if (en_r) begin
            acc_r <= sum_s[NCO_W-1:0];
         end
         if (carry_s) begin
            g1_r  <= lfsr_step(g1_r, G1_TAPS);
            g2_r  <= lfsr_step(g2_r, G2_TAPS);
            idx_r <= idx_next_s;
         end
         // The carry above used the old omega; the new one takes effect next cycle
         if (omega_upd) begin
            omega_r <= cfg.omega[NCO_W-1:0];
         end
      end
   end

   assign chip         = g1_r[9] ^ g2_tap(g2_r, t0_r) ^ g2_tap(g2_r, t1_r);
   assign chip_stb     = stb_r;
   assign epoch        = epoch_r;
   assign chip_idx     = idx_r;
   assign unused_cfg_s = ^{cfg.mode, cfg.omega};

endmodule

// File: rtl/cacode_nco_multi.sv
// NCH-channel C/A code generator with a shared single-slot valid/ready configuration port.
module cacode_nco_multi
   import cacode_pkg::*;
#(
   parameter  int NCH   = 4,
   parameter  int NCO_W = 16,
   localparam int CH_W  = (NCH > 1) ? $clog2(NCH) : 1
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              cfg_valid,
   output logic              cfg_ready,
   input  logic [CH_W-1:0]   cfg_ch,
   input  logic              cfg_mode,
   input  logic              cfg_en,
   input  logic [9:0]        cfg_g1,
   input  logic [9:0]        cfg_g2,
   input  logic [9:0]        cfg_idx,
   input  logic [3:0]        cfg_t0,
   input  logic [3:0]        cfg_t1,
   input  logic [NCO_W-1:0]  cfg_omega,
   output logic [NCH-1:0]    chip,
   output logic [NCH-1:0]    chip_stb,
   output logic [NCH-1:0]    epoch,
   output logic [NCH*10-1:0] chip_idx
);

   cfg_t            pend_r;
   logic [CH_W-1:0] pend_ch_r;
   logic            pend_vld_r;
   logic [NCH-1:0]  load_s;
   logic [NCH-1:0]  omega_upd_s;

   // Single-entry holding register: capture when empty, drain into a channel on the next clock
   always_ff @(posedge clk) begin
      if (!rst) begin
         pend_vld_r <= 1'b0;
         pend_ch_r  <= {CH_W{1'b0}};
         pend_r     <= '0;
      end else if (pend_vld_r) begin
         pend_vld_r <= 1'b0;
      end else if (cfg_valid) begin
         pend_vld_r   <= 1'b1;
         pend_ch_r    <= cfg_ch;
         pend_r.mode  <= cfg_mode ? MODE_OMEGA : MODE_FULL;
         pend_r.en    <= cfg_en;
         pend_r.g1    <= cfg_g1;
         pend_r.g2    <= cfg_g2;
         pend_r.idx   <= cfg_idx;
         pend_r.t0    <= cfg_t0;
         pend_r.t1    <= cfg_t1;
         pend_r.omega <= OMEGA_MAX_W'(cfg_omega);
      end
   end

   // Channel decode; channel numbers at or above NCH match nothing and are dropped
   always_comb begin
      load_s      = {NCH{1'b0}};
      omega_upd_s = {NCH{1'b0}};
      for (int n = 0; n < NCH; n++) begin
         if (pend_vld_r && (pend_ch_r == CH_W'(n))) begin
            if (pend_r.mode == MODE_FULL) begin
               load_s[n] = 1'b1;
            end else begin
               omega_upd_s[n] = 1'b1;
            end
         end else begin
            load_s[n]      = 1'b0;
            omega_upd_s[n] = 1'b0;
         end
      end
   end

   for (genvar n = 0; n < NCH; n++) begin : g_chan
      cacode_chan #(
         .NCO_W(NCO_W)
      ) u_chan (
         .clk      (clk),
         .rst      (rst),
         .load     (load_s[n]),
         .omega_upd(omega_upd_s[n]),
         .cfg      (pend_r),
         .chip     (chip[n]),
         .chip_stb (chip_stb[n]),
         .epoch    (epoch[n]),
         .chip_idx (chip_idx[10*n +: 10])
      );
   end

   assign cfg_ready = ~pend_vld_r;

endmodule

// File: tb/tb_cacode_nco_multi.sv
// Self-checking bench: golden C/A sequences from the generator polynomials plus an index-level channel model.
module tb_cacode_nco_multi;

   localparam int NCH   = 4;
   localparam int NCO_W = 16;

   logic          clk = 1'b0;
   logic          rst = 1'b0;
   logic          cfg_valid = 1'b0;
   logic          cfg_ready;
   logic [1:0]    cfg_ch = 2'd0;
   logic          cfg_mode = 1'b0;
   logic          cfg_en = 1'b0;
   logic [9:0]    cfg_g1 = 10'd0;
   logic [9:0]    cfg_g2 = 10'd0;
   logic [9:0]    cfg_idx = 10'd0;
   logic [3:0]    cfg_t0 = 4'd0;
   logic [3:0]    cfg_t1 = 4'd0;
   logic [15:0]   cfg_omega = 16'd0;
   logic [3:0]    chip;
   logic [3:0]    chip_stb;
   logic [3:0]    epoch;
   logic [39:0]   chip_idx;

   int checks = 0;
   int errors = 0;

   // Output sequences of G1/G2 from the all-ones state; stage k at chip n is seq[n+10-k]
   bit g1s[1040];
   bit g2s[1040];

   int m_acc[NCH];
   int m_om[NCH];
   int m_idx[NCH];
   int m_t0[NCH];
   int m_t1[NCH];
   bit m_en[NCH];
   bit m_stb[NCH];
   bit m_ep[NCH];
   bit m_pend;
   int p_ch, p_mode, p_en, p_idx, p_t0, p_t1, p_om;

   always #5 clk = ~clk;

   cacode_nco_multi #(.NCH(NCH), .NCO_W(NCO_W)) dut (
      .clk(clk), .rst(rst), .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
      .cfg_ch(cfg_ch), .cfg_mode(cfg_mode), .cfg_en(cfg_en),
      .cfg_g1(cfg_g1), .cfg_g2(cfg_g2), .cfg_idx(cfg_idx),
      .cfg_t0(cfg_t0), .cfg_t1(cfg_t1), .cfg_omega(cfg_omega),
      .chip(chip), .chip_stb(chip_stb), .epoch(epoch), .chip_idx(chip_idx)
   );

   function automatic bit gold(input int idx, input int t0, input int t1);
      bit c;
      c = g1s[idx];
      if (t0 >= 1 && t0 <= 10) c ^= g2s[idx + 10 - t0];
      if (t1 >= 1 && t1 <= 10) c ^= g2s[idx + 10 - t1];
      return c;
   endfunction

   function automatic logic [9:0] seed_of(input bit is_g2, input int n);
      logic [9:0] s;
      for (int k = 1; k <= 10; k++) s[k-1] = is_g2 ? g2s[n + 10 - k] : g1s[n + 10 - k];
      return s;
   endfunction

   task automatic model_edge();
      if (!rst) begin
         for (int n = 0; n < NCH; n++) begin
            m_acc[n] = 0; m_om[n] = 0; m_idx[n] = 0; m_en[n] = 0;
            m_t0[n] = 2; m_t1[n] = 6; m_stb[n] = 0; m_ep[n] = 0;
         end
         m_pend = 0;
      end else begin
         for (int n = 0; n < NCH; n++) begin
            bit hit;
            hit = m_pend && (p_ch == n);
            m_stb[n] = 0;
            m_ep[n]  = 0;
            if (hit && p_mode == 0) begin
               m_idx[n] = (p_idx > 1022) ? 1022 : p_idx;
               m_t0[n] = p_t0; m_t1[n] = p_t1; m_om[n] = p_om; m_en[n] = p_en[0]; m_acc[n] = 0;
            end else begin
               if (m_en[n]) begin
                  m_acc[n] += m_om[n];
                  if (m_acc[n] >= 65536) begin
                     m_acc[n] -= 65536;
                     m_stb[n] = 1;
                     if (m_idx[n] == 1022) begin
                        m_idx[n] = 0;
                        m_ep[n]  = 1;
                     end else begin
                        m_idx[n]++;
                     end
                  end
               end
               if (hit) m_om[n] = p_om;
            end
         end
         if (m_pend) begin
            m_pend = 0;
         end else if (cfg_valid) begin
            m_pend = 1; p_ch = int'(cfg_ch); p_mode = int'(cfg_mode); p_en = int'(cfg_en);
            p_idx = int'(cfg_idx); p_t0 = int'(cfg_t0); p_t1 = int'(cfg_t1); p_om = int'(cfg_omega);
         end
      end
   endtask

   task automatic tick();
      @(posedge clk);
      model_edge();
      #1;
   endtask

   task automatic send_cfg(input int ch, input int mode, input int en, input int idx,
                           input int t0, input int t1, input int om);
      int lim;
      int ci;
      lim = 0;
      while (cfg_ready !== 1'b1 && lim < 8) begin
         tick();
         lim++;
      end
      if (cfg_ready !== 1'b1) begin
         checks++; errors++;
         $display("FAIL cfg_ready_timeout got %b want 1", cfg_ready);
      end
      ci = (idx > 1022) ? 1022 : idx;
      cfg_ch = 2'(ch); cfg_mode = 1'(mode); cfg_en = 1'(en); cfg_idx = 10'(idx);
      cfg_g1 = seed_of(1'b0, ci); cfg_g2 = seed_of(1'b1, ci);
      cfg_t0 = 4'(t0); cfg_t1 = 4'(t1); cfg_omega = 16'(om);
      cfg_valid = 1'b1;
      tick();
      cfg_valid = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b0;
      tick();
      tick();
      checks++; if (cfg_ready !== 1'b1) begin errors++; $display("FAIL reset_ready got %b want 1", cfg_ready); end
      checks++; if (chip !== 4'hF) begin errors++; $display("FAIL reset_chip got %h want F", chip); end
      checks++; if (chip_stb !== 4'h0 || epoch !== 4'h0) begin errors++; $display("FAIL reset_pulses got %h/%h want 0/0", chip_stb, epoch); end
      checks++; if (chip_idx !== 40'd0) begin errors++; $display("FAIL reset_idx got %h want 0", chip_idx); end
      rst = 1'b1;
      tick();
   endtask

   task automatic test_prn1();
      logic [9:0] exp_chips;
      logic [9:0] got;
      int cnt, last;
      exp_chips = 10'b1100100000;
      send_cfg(0, 0, 1, 0, 2, 6, 16'h8000);
      tick();
      got[9] = chip[0];
      cnt = 1;
      last = 0;
      for (int c = 1; c <= 40 && cnt < 10; c++) begin
         tick();
         if (chip_stb[0]) begin
            checks++; if (c - last != 2) begin errors++; $display("FAIL prn1_period got %0d want 2", c - last); end
            got[9 - cnt] = chip[0];
            cnt++;
            last = c;
         end
      end
      checks++; if (got !== exp_chips || cnt != 10) begin errors++; $display("FAIL prn1_chips got %b (%0d) want %b", got, cnt, exp_chips); end
   endtask

   task automatic test_epoch();
      int ep_cnt, prev_idx;
      send_cfg(1, 0, 1, 0, 3, 7, 16'hFFFF);
      tick();
      ep_cnt = 0;
      prev_idx = int'(chip_idx[19:10]);
      for (int c = 0; c < 1024; c++) begin
         tick();
         checks++; if (chip[1] !== gold(m_idx[1], 3, 7) || chip_idx[19:10] !== 10'(m_idx[1])) begin
            errors++; $display("FAIL epoch_run c%0d got %b/%0d want %b/%0d", c, chip[1], chip_idx[19:10], gold(m_idx[1], 3, 7), m_idx[1]);
         end
         if (epoch[1]) begin
            ep_cnt++;
            checks++; if (prev_idx != 1022 || chip_idx[19:10] !== 10'd0) begin errors++; $display("FAIL epoch_wrap got %0d->%0d want 1022->0", prev_idx, chip_idx[19:10]); end
         end
         prev_idx = int'(chip_idx[19:10]);
      end
      checks++; if (ep_cnt != 1) begin errors++; $display("FAIL epoch_count got %0d want 1", ep_cnt); end
      checks++; if (chip_idx[19:10] !== 10'd0 || chip[1] !== gold(0, 3, 7)) begin errors++; $display("FAIL epoch_end got %0d/%b want 0/%b", chip_idx[19:10], chip[1], gold(0, 3, 7)); end
   endtask

   task automatic test_midcode();
      int cnt;
      send_cfg(2, 0, 1, 500, 2, 6, 16'h8000);
      tick();
      checks++; if (chip[2] !== gold(500, 2, 6)) begin errors++; $display("FAIL mid_chip0 got %b want %b", chip[2], gold(500, 2, 6)); end
      cnt = 1;
      for (int c = 0; c < 60 && cnt < 20; c++) begin
         tick();
         if (chip_stb[2]) begin
            checks++; if (chip[2] !== gold(500 + cnt, 2, 6) || chip_idx[29:20] !== 10'(500 + cnt)) begin
               errors++; $display("FAIL mid_chip %0d got %b/%0d want %b", 500 + cnt, chip[2], chip_idx[29:20], gold(500 + cnt, 2, 6));
            end
            cnt++;
         end
      end
      checks++; if (cnt != 20) begin errors++; $display("FAIL mid_count got %0d want 20", cnt); end
   endtask

   task automatic test_omega_update();
      int last, intv;
      send_cfg(3, 0, 1, 0, 1, 4, 16'h4000);
      tick();
      last = -1; intv = 0;
      for (int i = 0; i < 24; i++) begin
         tick();
         if (chip_stb[3]) begin
            if (last >= 0) intv = i - last;
            last = i;
         end
      end
      checks++; if (intv != 4) begin errors++; $display("FAIL omega_pre_period got %0d want 4", intv); end
      send_cfg(3, 1, 1, 700, 9, 9, 16'h8000);
      last = -1; intv = 0;
      for (int i = 0; i < 25; i++) begin
         tick();
         checks++; if (chip_idx[39:30] !== 10'(m_idx[3]) || chip[3] !== gold(m_idx[3], 1, 4)) begin
            errors++; $display("FAIL omega_cont i%0d got %0d/%b want %0d/%b", i, chip_idx[39:30], chip[3], m_idx[3], gold(m_idx[3], 1, 4));
         end
         if (chip_stb[3] && i > 2) begin
            if (last >= 0) intv = i - last;
            last = i;
         end
      end
      checks++; if (intv != 2) begin errors++; $display("FAIL omega_post_period got %0d want 2", intv); end
   endtask

   task automatic test_load_on_carry();
      int lim;
      bit due;
      logic [3:0] rdy;
      lim = 0;
      while (m_acc[0] != 0 && lim < 4) begin
         tick();
         lim++;
      end
      send_cfg(0, 0, 1, 100, 2, 6, 16'h2000);
      due = (m_acc[0] + m_om[0]) >= 65536;
      tick();
      checks++; if (!due || chip_stb[0] !== 1'b0) begin errors++; $display("FAIL carry_load_stb due %b got %b want 0", due, chip_stb[0]); end
      checks++; if (chip_idx[9:0] !== 10'd100 || chip[0] !== gold(100, 2, 6)) begin errors++; $display("FAIL carry_load_state got %0d/%b want 100/%b", chip_idx[9:0], chip[0], gold(100, 2, 6)); end
      for (int i = 0; i < 8; i++) begin
         tick();
         checks++; if (chip_stb[0] !== (i == 7)) begin errors++; $display("FAIL carry_load_acc i%0d got %b want %b", i, chip_stb[0], i == 7); end
      end
      cfg_ch = 2'd3; cfg_mode = 1'b0; cfg_en = 1'b1; cfg_idx = 10'd200;
      cfg_g1 = seed_of(1'b0, 200); cfg_g2 = seed_of(1'b1, 200);
      cfg_t0 = 4'd1; cfg_t1 = 4'd4; cfg_omega = 16'h1000;
      cfg_valid = 1'b1;
      for (int i = 0; i < 3; i++) begin
         tick();
         rdy[i] = cfg_ready;
      end
      cfg_valid = 1'b0;
      tick();
      rdy[3] = cfg_ready;
      checks++; if (rdy !== 4'b1010) begin errors++; $display("FAIL held_valid_ready got %b want 1010", rdy); end
   endtask

   task automatic test_reset_pending();
      send_cfg(1, 0, 1, 300, 2, 6, 16'hFFFF);
      rst = 1'b0;
      tick();
      rst = 1'b1;
      checks++; if (chip !== 4'hF || chip_idx !== 40'd0 || cfg_ready !== 1'b1) begin
         errors++; $display("FAIL rst_mid got chip %h idx %h rdy %b want F 0 1", chip, chip_idx, cfg_ready);
      end
      for (int i = 0; i < 6; i++) begin
         tick();
         checks++; if (chip_stb !== 4'h0 || epoch !== 4'h0 || chip_idx !== 40'd0) begin
            errors++; $display("FAIL rst_pending i%0d got stb %h ep %h idx %h want 0", i, chip_stb, epoch, chip_idx);
         end
      end
   endtask

   task automatic test_random();
      int idx, ci;
      for (int c = 0; c < 2500; c++) begin
         if (!cfg_valid && $urandom_range(0, 3) == 0) begin
            idx = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1015, 1023)) : int'($urandom_range(0, 1023));
            ci = (idx > 1022) ? 1022 : idx;
            cfg_ch = 2'($urandom_range(0, 3));
            cfg_mode = ($urandom_range(0, 3) == 0);
            cfg_en = ($urandom_range(0, 4) != 0);
            cfg_idx = 10'(idx);
            cfg_g1 = seed_of(1'b0, ci); cfg_g2 = seed_of(1'b1, ci);
            cfg_t0 = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(0, 15)) : 4'($urandom_range(1, 10));
            cfg_t1 = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(0, 15)) : 4'($urandom_range(1, 10));
            cfg_omega = ($urandom_range(0, 2) == 0) ? 16'($urandom_range(65000, 65535)) : 16'($urandom);
            cfg_valid = 1'b1;
         end
         tick();
         if (m_pend) cfg_valid = 1'b0;
         for (int n = 0; n < NCH; n++) begin
            checks++; if (chip[n] !== gold(m_idx[n], m_t0[n], m_t1[n])) begin errors++; $display("FAIL rnd_chip c%0d ch%0d got %b want %b", c, n, chip[n], gold(m_idx[n], m_t0[n], m_t1[n])); end
            checks++; if (chip_idx[10*n +: 10] !== 10'(m_idx[n])) begin errors++; $display("FAIL rnd_idx c%0d ch%0d got %0d want %0d", c, n, chip_idx[10*n +: 10], m_idx[n]); end
            checks++; if (chip_stb[n] !== m_stb[n]) begin errors++; $display("FAIL rnd_stb c%0d ch%0d got %b want %b", c, n, chip_stb[n], m_stb[n]); end
            checks++; if (epoch[n] !== m_ep[n]) begin errors++; $display("FAIL rnd_epoch c%0d ch%0d got %b want %b", c, n, epoch[n], m_ep[n]); end
         end
         checks++; if (cfg_ready !== !m_pend) begin errors++; $display("FAIL rnd_ready c%0d got %b want %b", c, cfg_ready, !m_pend); end
      end
   endtask

   initial begin
      for (int i = 0; i < 10; i++) begin
         g1s[i] = 1'b1;
         g2s[i] = 1'b1;
      end
      for (int i = 0; i + 10 < 1040; i++) begin
         g1s[i+10] = g1s[i+7] ^ g1s[i];
         g2s[i+10] = g2s[i+8] ^ g2s[i+7] ^ g2s[i+4] ^ g2s[i+2] ^ g2s[i+1] ^ g2s[i];
      end
      test_reset();
      test_prn1();
      test_epoch();
      test_midcode();
      test_omega_update();
      test_load_on_carry();
      test_reset_pending();
      test_random();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
